// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Purpose  : Read-side controller for a 1-word clock-crossing fifo, running in
//            the fifo output (clkout) domain. Captures fifo_dataout when a
//            word is available, holds fifo_rd high until fifo_empty_n drops
//            (so the write domain reliably sees the read), then presents the
//            word on a valid/ready stream.
// Ports    : clk, rst           - clock / asynchronous active-high reset
//            fifo_dataout       - fifo data (BUS_WIDTH)
//            fifo_empty_n       - 1 = fifo holds a word
//            fifo_rd            - registered fifo read level
//            out_data/out_valid - stream data / valid (registered)
//            out_ready          - stream ready from the consumer
//            word_cnt           - captured-word count, wraps at 2^CNT_WIDTH
//            busy               - state is not IDLE
//            timeout_err        - sticky ACK timeout flag
// Config   : FIFO_RD_TIMEOUT_EN - when defined, ACK gives up after
//            TIMEOUT_CYCLES cycles and sets timeout_err; otherwise ACK waits
//            indefinitely and timeout_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int BUS_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] fifo_dataout,
  input  logic                 fifo_empty_n,
  output logic                 fifo_rd,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic w_buf_free;
  logic w_xfer;
  logic w_capture;

  // The output register can take a new word if it is empty or being drained
  // on this very edge.
  assign w_buf_free = !valid_q || out_ready;
  assign w_xfer     = valid_q && out_ready;
  assign w_capture  = (state_q == IDLE) && fifo_empty_n && w_buf_free;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last ACK cycle index: the counter starts at 0 on the first ACK edge.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             terr_q, terr_d;
`endif

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef FIFO_RD_TIMEOUT_EN
    tmo_d   = tmo_q;
    terr_d  = terr_q;
`endif

    // Stream register: a capture wins over a same-edge transfer so that
    // back-to-back words keep valid asserted.
    if (w_capture) begin
      valid_d = 1'b1;
      data_d  = fifo_dataout;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end else if (w_xfer) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        if (w_capture) begin
          rd_d    = 1'b1;
          state_d = ACK;
`ifdef FIFO_RD_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ACK: begin
        rd_d = 1'b1;
        if (!fifo_empty_n) begin
          rd_d    = 1'b0;
          state_d = RELEASE;
        end
`ifdef FIFO_RD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // Write side never acknowledged; give up but keep the word.
          rd_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      RELEASE: begin
        // Wait for empty_n low so a stale word after a timeout is not
        // captured a second time.
        rd_d = 1'b0;
        if (!fifo_empty_n) begin
          state_d = IDLE;
        end
      end
      default: begin
        rd_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_RD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign fifo_rd   = rd_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign word_cnt  = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Purpose  : Self-checking bench for fifo_rd_ctrl. Stimulus pushes each
//            offered word into an expected queue; a monitor pops and compares
//            on every stream transfer. Directed checks cover reset, rd
//            timing, backpressure, timeout, async reset and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int BW = 16;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] fifo_dataout = '0;
  logic          fifo_empty_n = 1'b0;
  logic          fifo_rd;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] word_cnt;
  logic          busy;
  logic          timeout_err;

  fifo_rd_ctrl #(
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_dataout(fifo_dataout),
    .fifo_empty_n(fifo_empty_n),
    .fifo_rd     (fifo_rd),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .word_cnt    (word_cnt),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: inputs change just after posedge, so the negedge view predicts
  // whether the next edge performs a transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL stream_extra: got 0x%0h expected no word", out_data);
      end else begin
        check("stream_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [BW-1:0] d);
    fifo_dataout = d;
    fifo_empty_n = 1'b1;
    exp_q.push_back(d);
  endtask

  // Wait for the capture edge, then check the captured word is on the stream.
  task automatic wait_rd(input logic [BW-1:0] d);
    int n = 0;
    while (!fifo_rd && n < 100) begin
      step;
      n++;
    end
    check("rd_rise", fifo_rd, 1);
    check("cap_valid", out_valid, 1);
    check("cap_data", out_data, d);
  endtask

  // Drop empty_n after 'hold' cycles of rd high; returns measured rd-high cycles.
  task automatic release_word(input int hold, output int hi);
    int n = 0;
    hi = 1;
    repeat (hold - 1) begin
      step;
      if (fifo_rd) hi++;
    end
    fifo_empty_n = 1'b0;
    while (fifo_rd && n < 100) begin
      step;
      if (fifo_rd) hi++;
      n++;
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 100) begin
      step;
      n++;
    end
    check("idle", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic seen;
    logic [BW-1:0] d;

    // Reset state
    #2;
    check("rst_rd", fifo_rd, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    repeat (2) step;
    rst = 1'b0;
    out_ready = 1'b1;
    step;

    // 1: single word, empty_n falls 3 cycles after rd rises
    present(16'hA5A5);
    wait_rd(16'hA5A5);
    release_word(3, hi);
    check("t1_rd_high", hi, 3);
    check("t1_valid_clr", out_valid, 0);
    check("t1_cnt", word_cnt, 1);
    wait_idle;

    // 2: backpressure holds the first word and blocks the second capture
    out_ready = 1'b0;
    present(16'h1234);
    wait_rd(16'h1234);
    release_word(1, hi);
    check("t2_rd_high", hi, 1);
    wait_idle;
    present(16'h5678);
    repeat (5) step;
    check("t2_rd_blocked", fifo_rd, 0);
    check("t2_hold_data", out_data, 16'h1234);
    check("t2_hold_valid", out_valid, 1);
    check("t2_cnt", word_cnt, 2);
    out_ready = 1'b1;
    wait_rd(16'h5678);
    release_word(1, hi);
    wait_idle;
    check("t2_cnt2", word_cnt, 3);

    // 3: ACK timeout with empty_n stuck high
`ifdef FIFO_RD_TIMEOUT_EN
    check("t3_terr_pre", timeout_err, 0);
    present(16'h9ABC);
    wait_rd(16'h9ABC);
    hi = 1;
    for (int n = 0; n < 50 && fifo_rd; n++) begin
      step;
      if (fifo_rd) hi++;
    end
    check("t3_rd_high", hi, TO);
    check("t3_terr", timeout_err, 1);
    seen = 1'b0;
    repeat (10) begin
      step;
      if (fifo_rd) seen = 1'b1;
    end
    check("t3_no_recapture", seen, 0);
    check("t3_cnt", word_cnt, 4);
    fifo_empty_n = 1'b0;
    wait_idle;
    check("t3_terr_sticky", timeout_err, 1);
`else
    check("t3_terr_tied", timeout_err, 0);
`endif

    // 4: asynchronous reset while rd is high, between clock edges
    out_ready = 1'b0;
    present(16'h0BAD);
    wait_rd(16'h0BAD);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rd", fifo_rd, 0);
    check("t4_valid", out_valid, 0);
    check("t4_cnt", word_cnt, 0);
    check("t4_busy", busy, 0);
    check("t4_terr", timeout_err, 0);
    exp_q.delete();
    fifo_empty_n = 1'b0;
    repeat (2) step;
    rst = 1'b0;
    step;

    // 5/6: 17 words, each capture coinciding with the previous transfer
    for (int i = 0; i < 17; i++) begin
      d = 16'(16'h1357 + i * 16'h0F0F);
      present(d);
      out_ready = 1'b1;
      wait_rd(d);
      out_ready = 1'b0;
      release_word(1 + (i % 3), hi);
      check("t5_rd_high", hi, 1 + (i % 3));
      wait_idle;
    end
    out_ready = 1'b1;
    repeat (2) step;
    check("t5_valid_end", out_valid, 0);
    check("t5_cnt_wrap", word_cnt, 1);
    check("t5_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
